// File: rtl/rect_overlay_gen.sv
// Rectangle overlay generator: programmable, double-buffered rectangles drawn over
// the pixel-counter position, with blink and a 2-cycle hit/priority pipeline.

module rect_hit #(
  parameter int COORD_W = 10
) (
  input  logic               en,
  input  logic               blink,
  input  logic               phase,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic               hit
);
  // Inverted bounds (x0>x1 or y0>y1) naturally never satisfy both compares.
  assign hit = en && !(blink && phase) &&
               (pos_x >= x0) && (pos_x <= x1) &&
               (pos_y >= y0) && (pos_y <= y1);
endmodule

module rect_overlay_gen #(
  parameter int NUM_RECTS    = 16,
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 3,
  parameter int H_START      = 48,
  parameter int H_END        = 640,
  parameter int V_START      = 33,
  parameter int V_END        = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           pos_x,
  input  logic [COORD_W-1:0]           pos_y,
  input  logic                         frame_sync,
  input  logic                         cfg_we,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_RECTS)-1:0] cfg_addr,
  input  logic [COORD_W-1:0]           cfg_x0,
  input  logic [COORD_W-1:0]           cfg_x1,
  input  logic [COORD_W-1:0]           cfg_y0,
  input  logic [COORD_W-1:0]           cfg_y1,
  input  logic [COLOR_W-1:0]           cfg_color,
  input  logic                         cfg_en,
  input  logic                         cfg_blink,
  output logic                         cfg_pending,
  output logic                         blank,
  output logic                         letra,
  output logic [COLOR_W-1:0]           color,
  output logic [$clog2(NUM_RECTS)-1:0] hit_idx
);
  localparam int AW     = $clog2(NUM_RECTS);
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic               en;
    logic               blink;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
  } rect_t;

  rect_t [NUM_RECTS-1:0] shadow, active;
  rect_t                 wr_rect;
  logic                  wr_go;

  // vld_pipe[0] is the live input side; [k] marks stage k holding post-reset data.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_q;
  assign vld_pipe = {vld_q, ~reset};

  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  assign cfg_ready = vld_pipe[1];
  assign wr_go     = cfg_we && cfg_ready;
  assign wr_rect   = '{en: cfg_en, blink: cfg_blink, color: cfg_color,
                       x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1};

  // Commit copies the pre-edge shadow, so a same-cycle write waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      active      <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (frame_sync) active <= shadow;
      if (wr_go) shadow[cfg_addr] <= wr_rect;
      if (wr_go)           cfg_pending <= 1'b1;
      else if (frame_sync) cfg_pending <= 1'b0;
    end
  end

  logic [FC_W-1:0] fcnt;
  logic            blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (frame_sync) begin
      if (fcnt == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  logic [NUM_RECTS-1:0] hit_c;
  logic                 blank_c;

  for (genvar i = 0; i < NUM_RECTS; i++) begin : g_hit
    rect_hit #(.COORD_W(COORD_W)) u_hit (
      .en    (active[i].en),
      .blink (active[i].blink),
      .phase (blink_phase),
      .x0    (active[i].x0),
      .x1    (active[i].x1),
      .y0    (active[i].y0),
      .y1    (active[i].y1),
      .pos_x (pos_x),
      .pos_y (pos_y),
      .hit   (hit_c[i])
    );
  end

  assign blank_c = (pos_x <= COORD_W'(H_START)) || (pos_x >= COORD_W'(H_END)) ||
                   (pos_y <= COORD_W'(V_START)) || (pos_y >= COORD_W'(V_END));

  // Stage 1: blank + raw hit vector.
  logic                 blank1;
  logic [NUM_RECTS-1:0] hit1;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank1 <= 1'b0;
      hit1   <= '0;
    end else begin
      blank1 <= blank_c;
      hit1   <= hit_c;
    end
  end

  // Lowest set index wins.
  logic          win_any;
  logic [AW-1:0] win_idx;

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        win_any = 1'b1;
        win_idx = AW'(i);
      end
    end
  end

  // Stage 2: registered outputs.
  logic               blank_q, letra_q;
  logic [COLOR_W-1:0] color_q;
  logic [AW-1:0]      idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= 1'b0;
      letra_q <= 1'b0;
      color_q <= '0;
      idx_q   <= '0;
    end else begin
      blank_q <= blank1;
      if (blank1 || !win_any) begin
        letra_q <= 1'b0;
        color_q <= '0;
        idx_q   <= '0;
      end else begin
        letra_q <= 1'b1;
        color_q <= active[win_idx].color;
        idx_q   <= win_idx;
      end
    end
  end

  assign blank   = blank_q & vld_pipe[STAGES];
  assign letra   = letra_q & vld_pipe[STAGES];
  assign color   = color_q & {COLOR_W{vld_pipe[STAGES]}};
  assign hit_idx = idx_q & {AW{vld_pipe[STAGES]}};

endmodule

// File: tb/tb_rect_overlay_gen.sv
// Scoreboard bench for rect_overlay_gen: a behavioural model predicts each probed
// pixel, the prediction is queued and compared when the 2-cycle pipeline delivers it.

module tb_rect_overlay_gen;
  localparam int NR = 16;
  localparam int CW = 10;
  localparam int KW = 3;
  localparam int AW = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] pos_x = '0, pos_y = '0;
  logic          frame_sync = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
  logic [KW-1:0] cfg_color = '0;
  logic          cfg_en = 1'b0, cfg_blink = 1'b0;
  logic          cfg_pending, blank, letra;
  logic [KW-1:0] color;
  logic [AW-1:0] hit_idx;

  rect_overlay_gen #(.NUM_RECTS(NR), .COORD_W(CW), .COLOR_W(KW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y), .frame_sync(frame_sync),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .cfg_pending(cfg_pending), .blank(blank), .letra(letra), .color(color), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en, blink;
    int x0, x1, y0, y1, col;
  } mrect_t;

  typedef logic [8:0] exp_t;  // {blank, letra, color[2:0], idx[3:0]}

  mrect_t m_sh[NR], m_act[NR];
  int     m_cnt;
  bit     m_phase, m_pend;
  exp_t   exp_q[$];
  int     checks = 0, errors = 0;
  logic   drv_flag = 1'b0;
  logic [1:0] tag_pipe = '0;

  always @(posedge clk) tag_pipe <= {tag_pipe[0], drv_flag};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int x, int y);
    if (x <= 48 || x >= 640 || y <= 33 || y >= 480) return 9'h100;
    for (int i = 0; i < NR; i++)
      if (m_act[i].en && !(m_act[i].blink && m_phase) &&
          x >= m_act[i].x0 && x <= m_act[i].x1 && y >= m_act[i].y0 && y <= m_act[i].y1)
        return {1'b0, 1'b1, 3'(m_act[i].col), 4'(i)};
    return 9'h000;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 0, 0, 0};
      m_act[i] = '{0, 0, 0, 0, 0, 0, 0};
    end
    m_cnt = 0; m_phase = 0; m_pend = 0;
  endfunction

  function automatic void model_commit();
    m_act = m_sh;
    m_pend = 0;
    if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
    else m_cnt++;
  endfunction

  // Advance one clock; compare any pixel whose pipeline result is now on the outputs.
  task automatic step();
    exp_t e;
    @(posedge clk); #1;
    drv_flag = 1'b0; cfg_we = 1'b0; frame_sync = 1'b0;
    if (tag_pipe[1]) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("blank@%0d,%0d", pos_x, pos_y), blank, e[8]);
        chk("letra", letra, e[7]);
        chk("color", color, e[6:4]);
        chk("hit_idx", hit_idx, e[3:0]);
      end
    end
  endtask

  task automatic px(input int x, input int y);
    pos_x = CW'(x); pos_y = CW'(y);
    drv_flag = 1'b1;
    exp_q.push_back(model(x, y));
    step();
  endtask

  task automatic flush();
    pos_x = '0; pos_y = '0;
    repeat (3) step();
  endtask

  task automatic wr(input int a, input int x0, input int x1, input int y0, input int y1,
                    input int col, input bit en, input bit bl, input bit with_fs);
    cfg_addr = AW'(a); cfg_x0 = CW'(x0); cfg_x1 = CW'(x1); cfg_y0 = CW'(y0); cfg_y1 = CW'(y1);
    cfg_color = KW'(col); cfg_en = en; cfg_blink = bl; cfg_we = 1'b1;
    frame_sync = with_fs;
    if (with_fs) model_commit();
    m_sh[a] = '{en, bl, x0, x1, y0, y1, col};
    m_pend = 1;
    step();
  endtask

  task automatic fs();
    frame_sync = 1'b1;
    model_commit();
    step();
  endtask

  initial begin
    model_reset();
    pos_x = 10'd100; pos_y = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blank", blank, 0);
    chk("rst_letra", letra, 0);
    chk("rst_color", color, 0);
    chk("rst_idx", hit_idx, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_ready", cfg_ready, 0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", cfg_ready, 1);
    chk("post_rst_blank", blank, 0);
    chk("post_rst_letra", letra, 0);

    // Blank edges, no slots
    px(48, 100); px(49, 34); px(100, 480); px(639, 479); px(640, 100); px(100, 33);
    flush();

    // Double buffering
    wr(0, 208, 224, 138, 196, 5, 1, 0, 0);
    chk("pend_after_wr", cfg_pending, m_pend);
    px(210, 150);
    flush();
    fs();
    chk("pend_after_fs", cfg_pending, m_pend);
    px(210, 150); px(208, 138); px(224, 196); px(225, 150); px(210, 137);
    flush();

    // Priority / overlap
    wr(3, 200, 300, 100, 200, 2, 1, 0, 0);
    wr(1, 250, 260, 150, 160, 6, 1, 0, 0);
    fs();
    px(255, 155); px(210, 110); px(301, 110); px(260, 160); px(261, 160);
    flush();

    // Zero-width column
    wr(4, 400, 400, 300, 310, 7, 1, 0, 0);
    fs();
    px(399, 305); px(400, 305); px(401, 305);
    flush();

    // Write on the frame_sync cycle lands in shadow only
    wr(2, 500, 520, 50, 60, 3, 1, 0, 1);
    chk("pend_same_cycle", cfg_pending, 1);
    px(510, 55);
    flush();
    fs();
    chk("pend_cleared", cfg_pending, 0);
    px(510, 55);
    flush();

    // Inverted bounds never hit
    wr(5, 300, 200, 400, 420, 1, 1, 0, 0);
    fs();
    px(250, 410); px(300, 410); px(200, 410);
    flush();

    // Reset mid-frame empties the display at once
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    step();
    chk("midrst_pending", cfg_pending, 0);
    px(255, 155); px(210, 150);
    flush();

    // Blink with BLINK_FRAMES=2: slot 6 blinks, slot 7 steady
    wr(6, 100, 150, 300, 350, 4, 1, 1, 0);
    wr(7, 160, 200, 300, 350, 1, 1, 0, 0);
    for (int f = 1; f <= 4; f++) begin
      fs();
      px(120, 320); px(180, 320);
      flush();
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
